// File: rtl/genius_pkg.sv
// Shared constants and elaboration helpers for the generalised Genius datapath.
package genius_pkg;

    localparam int N_BOTOES_DEF   = 4;
    localparam int PROF_DEF       = 16;
    localparam int T_JOGADA_DEF   = 5000;
    localparam int T_PRIMEIRA_DEF = 2000;
    localparam int T_LED_DEF      = 1000;

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fluxo_dados_genius_n_contador_m.sv
// Modulo-M up-counter with async reset, sync clear priority, terminal and half-period flags.
module contador_m
    import genius_pkg::*;
#(
    parameter int M = 100
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_zera,
    input  logic i_conta,
    output logic o_fim,
    output logic o_meio
);

    localparam int W = clog2(M);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_q <= '0;
        else if (i_zera)
            r_q <= '0;
        else if (i_conta)
            r_q <= (r_q == W'(M - 1)) ? '0 : r_q + 1'b1;
    end

    assign o_fim  = (r_q == W'(M - 1));
    assign o_meio = (r_q >= W'(M / 2));

endmodule

// File: rtl/fluxo_dados_genius_n.sv
// Genius game datapath: address/round counters, move register, sequence RAM,
// move timers and LED playback blink, all strobed by the game FSM.
module fluxo_dados_genius_n
    import genius_pkg::*;
#(
    parameter int N_BOTOES   = N_BOTOES_DEF,
    parameter int PROF       = PROF_DEF,
    parameter int T_JOGADA   = T_JOGADA_DEF,
    parameter int T_PRIMEIRA = T_PRIMEIRA_DEF,
    parameter int T_LED      = T_LED_DEF,
    localparam int AW        = clog2(PROF)
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_zeraE,
    input  logic                i_contaE,
    input  logic                i_zeraRod,
    input  logic                i_contaRod,
    input  logic                i_zeraT,
    input  logic                i_contaT,
    input  logic                i_zeraP,
    input  logic                i_contaP,
    input  logic                i_zeraL,
    input  logic                i_contaL,
    input  logic                i_zeraR,
    input  logic                i_registraR,
    input  logic                i_we,
    input  logic                i_sinal_led,
    input  logic                i_modo,
    input  logic [N_BOTOES-1:0] i_botoes,
    output logic                o_fimE,
    output logic                o_fimRod,
    output logic                o_fimT,
    output logic                o_fimP,
    output logic                o_fimL,
    output logic                o_meioL,
    output logic                o_igual,
    output logic                o_enderecoIgualRodada,
    output logic                o_jogada_feita,
    output logic                o_jogada_valida,
    output logic [N_BOTOES-1:0] o_leds,
    output logic [AW-1:0]       o_db_contagem,
    output logic [AW-1:0]       o_db_rodada,
    output logic [N_BOTOES-1:0] o_db_jogada,
    output logic [N_BOTOES-1:0] o_db_memoria
);

    logic [AW-1:0]       r_endereco;
    logic [AW-1:0]       r_rodada;
    logic [N_BOTOES-1:0] r_jogada;
    logic                r_s_ant;
    logic [N_BOTOES-1:0] r_mem [PROF];

    logic [AW-1:0]       w_ultima;
    logic [N_BOTOES-1:0] w_dado;
    logic                w_s;
    logic                w_meioT;
    logic                w_meioP;
    logic                w_unused;

    // Last round follows modo combinationally so a mid-game switch takes effect at once.
    assign w_ultima = i_modo ? AW'(PROF - 1) : AW'(PROF / 2 - 1);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_endereco <= '0;
        else if (i_zeraE)
            r_endereco <= '0;
        else if (i_contaE)
            r_endereco <= r_endereco + 1'b1;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_rodada <= '0;
        else if (i_zeraRod)
            r_rodada <= '0;
        else if (i_contaRod && (r_rodada < w_ultima))
            r_rodada <= r_rodada + 1'b1;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_jogada <= '0;
        else if (i_zeraR)
            r_jogada <= '0;
        else if (i_registraR)
            r_jogada <= i_botoes;
    end

    assign w_s = |i_botoes;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_s_ant <= 1'b0;
        else if (i_zeraRod)
            r_s_ant <= 1'b0;
        else
            r_s_ant <= w_s;
    end

    // Sequence contents survive reset; only the write port is clocked.
    always_ff @(posedge i_clock) begin
        if (i_we)
            r_mem[r_endereco] <= r_jogada;
    end

    assign w_dado = r_mem[r_endereco];

    contador_m #(.M(T_JOGADA)) u_timer_t (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_zera  (i_zeraT),
        .i_conta (i_contaT),
        .o_fim   (o_fimT),
        .o_meio  (w_meioT)
    );

    contador_m #(.M(T_PRIMEIRA)) u_timer_p (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_zera  (i_zeraP),
        .i_conta (i_contaP),
        .o_fim   (o_fimP),
        .o_meio  (w_meioP)
    );

    contador_m #(.M(T_LED)) u_timer_l (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_zera  (i_zeraL),
        .i_conta (i_contaL),
        .o_fim   (o_fimL),
        .o_meio  (o_meioL)
    );

    assign w_unused = w_meioT ^ w_meioP;

    assign o_fimE                = (r_endereco == AW'(PROF - 1));
    assign o_fimRod              = (r_rodada == w_ultima);
    assign o_igual               = (w_dado == r_jogada);
    assign o_enderecoIgualRodada = (r_endereco == r_rodada);
    assign o_jogada_feita        = w_s & ~r_s_ant;
    assign o_jogada_valida       = (r_jogada != '0) && ((r_jogada & (r_jogada - 1'b1)) == '0);
    assign o_leds                = i_sinal_led ? (o_meioL ? '0 : w_dado) : r_jogada;
    assign o_db_contagem         = r_endereco;
    assign o_db_rodada           = r_rodada;
    assign o_db_jogada           = r_jogada;
    assign o_db_memoria          = w_dado;

endmodule

// File: tb/tb_fluxo_dados_genius_n.sv
// Directed bench for fluxo_dados_genius_n with default parameters.
module tb_fluxo_dados_genius_n;

    logic       clk = 1'b0;
    logic       reset;
    logic       zeraE, contaE, zeraRod, contaRod, zeraT, contaT;
    logic       zeraP, contaP, zeraL, contaL, zeraR, registraR;
    logic       we, sinal_led, modo;
    logic [3:0] botoes;
    logic       fimE, fimRod, fimT, fimP, fimL, meioL, igual, endIgualRod;
    logic       jogada_feita, jogada_valida;
    logic [3:0] leds, db_jogada, db_memoria;
    logic [3:0] db_contagem, db_rodada;

    int checks = 0;
    int errors = 0;

    fluxo_dados_genius_n dut (
        .i_clock               (clk),
        .i_reset               (reset),
        .i_zeraE               (zeraE),
        .i_contaE              (contaE),
        .i_zeraRod             (zeraRod),
        .i_contaRod            (contaRod),
        .i_zeraT               (zeraT),
        .i_contaT              (contaT),
        .i_zeraP               (zeraP),
        .i_contaP              (contaP),
        .i_zeraL               (zeraL),
        .i_contaL              (contaL),
        .i_zeraR               (zeraR),
        .i_registraR           (registraR),
        .i_we                  (we),
        .i_sinal_led           (sinal_led),
        .i_modo                (modo),
        .i_botoes              (botoes),
        .o_fimE                (fimE),
        .o_fimRod              (fimRod),
        .o_fimT                (fimT),
        .o_fimP                (fimP),
        .o_fimL                (fimL),
        .o_meioL               (meioL),
        .o_igual               (igual),
        .o_enderecoIgualRodada (endIgualRod),
        .o_jogada_feita        (jogada_feita),
        .o_jogada_valida       (jogada_valida),
        .o_leds                (leds),
        .o_db_contagem         (db_contagem),
        .o_db_rodada           (db_rodada),
        .o_db_jogada           (db_jogada),
        .o_db_memoria          (db_memoria)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] botoes;
        logic       zera;
        logic       registra;
        logic [3:0] exp_jogada;
        logic       exp_valida;
    } vec_t;

    vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int pulses;

        tbl[0] = '{4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1};
        tbl[1] = '{4'b0110, 1'b0, 1'b1, 4'b0110, 1'b0};
        tbl[2] = '{4'b1000, 1'b0, 1'b1, 4'b1000, 1'b1};
        tbl[3] = '{4'b0011, 1'b0, 1'b0, 4'b1000, 1'b1};
        tbl[4] = '{4'b1111, 1'b0, 1'b1, 4'b1111, 1'b0};
        tbl[5] = '{4'b0100, 1'b1, 1'b1, 4'b0000, 1'b0};
        tbl[6] = '{4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1};
        tbl[7] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0};

        reset = 1'b1;
        {zeraE, contaE, zeraRod, contaRod, zeraT, contaT} = '0;
        {zeraP, contaP, zeraL, contaL, zeraR, registraR} = '0;
        {we, sinal_led, modo} = '0;
        botoes = '0;
        #3;
        chk("rst_contagem", db_contagem, 0);
        chk("rst_rodada", db_rodada, 0);
        chk("rst_fimE", fimE, 0);
        chk("rst_fimRod", fimRod, 0);
        chk("rst_fim_timers", {fimT, fimP, fimL}, 0);
        chk("rst_jogada_feita", jogada_feita, 0);
        chk("rst_jogada_valida", jogada_valida, 0);
        chk("rst_leds", leds, 0);
        chk("rst_endIgualRod", endIgualRod, 1);
        tick();
        reset = 1'b0;

        // Move register load / clear / one-hot table
        for (int i = 0; i < 8; i++) begin
            botoes    = tbl[i].botoes;
            zeraR     = tbl[i].zera;
            registraR = tbl[i].registra;
            tick();
            chk($sformatf("tbl%0d_jogada", i), db_jogada, tbl[i].exp_jogada);
            chk($sformatf("tbl%0d_leds", i), leds, tbl[i].exp_jogada);
            chk($sformatf("tbl%0d_valida", i), jogada_valida, tbl[i].exp_valida);
        end
        zeraR = 1'b0;
        registraR = 1'b0;
        botoes = '0;
        tick();
        tick();

        // Held button gives exactly one same-cycle pulse
        botoes = 4'b0100;
        #1;
        chk("edge_immediate", jogada_feita, 1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (jogada_feita) pulses++;
            tick();
        end
        chk("edge_single_pulse", pulses, 1);
        botoes = '0;
        tick();

        // Async reset in the middle of address counting
        contaE = 1'b1;
        repeat (5) tick();
        chk("count5_contagem", db_contagem, 5);
        chk("count5_endIgualRod", endIgualRod, 0);
        contaE = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_contagem", db_contagem, 0);
        chk("async_rst_fimE", fimE, 0);
        chk("async_rst_leds", leds, 0);
        tick();
        reset = 1'b0;

        // Address wrap
        contaE = 1'b1;
        repeat (15) tick();
        chk("addr15", db_contagem, 15);
        chk("addr15_fimE", fimE, 1);
        tick();
        chk("addr_wrap", db_contagem, 0);
        chk("addr_wrap_fimE", fimE, 0);
        contaE = 1'b0;

        // Round saturation and modo
        modo = 1'b0;
        contaRod = 1'b1;
        repeat (7) tick();
        chk("rod7", db_rodada, 7);
        chk("rod7_fimRod", fimRod, 1);
        tick();
        chk("rod_sat", db_rodada, 7);
        modo = 1'b1;
        #1;
        chk("modo1_fimRod", fimRod, 0);
        repeat (8) tick();
        chk("rod15", db_rodada, 15);
        chk("rod15_fimRod", fimRod, 1);
        tick();
        chk("rod15_sat", db_rodada, 15);
        zeraRod = 1'b1;
        tick();
        chk("rod_zera_prio", db_rodada, 0);
        zeraRod = 1'b0;
        contaRod = 1'b0;
        modo = 1'b0;

        // Write / compare at address 3, including read-during-write
        zeraE = 1'b1;
        tick();
        zeraE = 1'b0;
        contaE = 1'b1;
        repeat (3) tick();
        contaE = 1'b0;
        chk("addr3", db_contagem, 3);
        botoes = 4'b0010;
        registraR = 1'b1;
        tick();
        registraR = 1'b0;
        we = 1'b1;
        tick();
        we = 1'b0;
        chk("wr_mem", db_memoria, 4'b0010);
        chk("wr_igual", igual, 1);
        botoes = 4'b1000;
        registraR = 1'b1;
        tick();
        registraR = 1'b0;
        chk("reload_igual0", igual, 0);
        we = 1'b1;
        #1;
        chk("rdw_old", db_memoria, 4'b0010);
        tick();
        we = 1'b0;
        chk("rdw_new", db_memoria, 4'b1000);
        chk("rdw_igual", igual, 1);
        botoes = 4'b0010;
        registraR = 1'b1;
        tick();
        registraR = 1'b0;
        chk("reload2_igual0", igual, 0);
        botoes = '0;

        // Timer T: clear beats count at Q=4, then full period
        contaT = 1'b1;
        repeat (4) tick();
        zeraT = 1'b1;
        tick();
        zeraT = 1'b0;
        for (int i = 1; i <= 5000; i++) begin
            tick();
            if (i == 4998) chk("T_4998", fimT, 0);
            if (i == 4999) chk("T_4999", fimT, 1);
            if (i == 5000) chk("T_wrap", fimT, 0);
        end
        contaT = 1'b0;

        // Timer P
        contaP = 1'b1;
        for (int i = 1; i <= 1999; i++) begin
            tick();
            if (i == 1998) chk("P_1998", fimP, 0);
            if (i == 1999) chk("P_1999", fimP, 1);
        end
        contaP = 1'b0;
        tick();
        chk("P_hold", fimP, 1);

        // LED blink with memory data 0001 at address 3
        botoes = 4'b0001;
        registraR = 1'b1;
        tick();
        registraR = 1'b0;
        we = 1'b1;
        tick();
        we = 1'b0;
        botoes = '0;
        sinal_led = 1'b1;
        zeraL = 1'b1;
        tick();
        zeraL = 1'b0;
        contaL = 1'b1;
        for (int i = 0; i <= 1000; i++) begin
            if (i == 0)    chk("L0_leds", leds, 4'b0001);
            if (i == 499)  chk("L499_leds", leds, 4'b0001);
            if (i == 499)  chk("L499_meio", meioL, 0);
            if (i == 500)  chk("L500_leds", leds, 4'b0000);
            if (i == 500)  chk("L500_meio", meioL, 1);
            if (i == 999)  chk("L999_leds", leds, 4'b0000);
            if (i == 999)  chk("L999_fim", fimL, 1);
            if (i == 1000) chk("L_wrap_leds", leds, 4'b0001);
            if (i == 1000) chk("L_wrap_fim", fimL, 0);
            tick();
        end
        contaL = 1'b0;
        sinal_led = 1'b0;
        #1;
        chk("leds_reg_view", leds, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
